// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcodes, boundary-scan control bit map.
package jtag_pkg;

    localparam int unsigned STATE_W    = 4;
    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned BSR_CTRL_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_TLR    = 4'hF,
        ST_RTI    = 4'hC,
        ST_SEL_DR = 4'h7,
        ST_CAP_DR = 4'h6,
        ST_SH_DR  = 4'h2,
        ST_EX1_DR = 4'h1,
        ST_PA_DR  = 4'h3,
        ST_EX2_DR = 4'h0,
        ST_UP_DR  = 4'h5,
        ST_SEL_IR = 4'h4,
        ST_CAP_IR = 4'hE,
        ST_SH_IR  = 4'hA,
        ST_EX1_IR = 4'h9,
        ST_PA_IR  = 4'hB,
        ST_EX2_IR = 4'h8,
        ST_UP_IR  = 4'hD
    } tap_state_e;

    localparam logic [OPCODE_W-1:0] OP_EXTEST  = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SAMPLE  = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_IDCODE  = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_BYPASS  = 4'b1111;
    localparam logic [OPCODE_W-1:0] IR_CAPTURE = 4'b0101;

    localparam int unsigned BSR_CAPTURE = 0;
    localparam int unsigned BSR_SHIFT   = 1;
    localparam int unsigned BSR_UPDATE  = 2;
    localparam int unsigned BSR_MODE    = 3;

endpackage

// File: rtl/jtag_tap_controller_if.sv
// JTAG pin-side bundle plus the boundary-scan chain hookup.
interface jtag_tap_controller_if #(
    parameter int unsigned IR_WIDTH = 4
);
    logic                tms;
    logic                tdi;
    logic                bsr_tdo;
    logic                tdo;
    logic                tdo_en;
    logic [3:0]          bsr_control;
    logic [3:0]          tap_state;
    logic [IR_WIDTH-1:0] ir_value;

    modport master (
        output tms, tdi, bsr_tdo,
        input  tdo, tdo_en, bsr_control, tap_state, ir_value
    );

    modport slave (
        input  tms, tdi, bsr_tdo,
        output tdo, tdo_en, bsr_control, tap_state, ir_value
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP state machine; next state depends on tms only.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    output tap_state_e state,
    output tap_state_e next_state_c
);

    // State register; reset overrides tms
    always_ff @(posedge tck) begin
        if (reset) state <= ST_TLR;
        else       state <= next_state_c;
    end

    // TAP transition graph
    always_comb begin
        next_state_c = state;
        case (state)
            ST_TLR:    next_state_c = tms ? ST_TLR    : ST_RTI;
            ST_RTI:    next_state_c = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: next_state_c = tms ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: next_state_c = tms ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  next_state_c = tms ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: next_state_c = tms ? ST_UP_DR  : ST_PA_DR;
            ST_PA_DR:  next_state_c = tms ? ST_EX2_DR : ST_PA_DR;
            ST_EX2_DR: next_state_c = tms ? ST_UP_DR  : ST_SH_DR;
            ST_UP_DR:  next_state_c = tms ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: next_state_c = tms ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: next_state_c = tms ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  next_state_c = tms ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: next_state_c = tms ? ST_UP_IR  : ST_PA_IR;
            ST_PA_IR:  next_state_c = tms ? ST_EX2_IR : ST_PA_IR;
            ST_EX2_IR: next_state_c = tms ? ST_UP_IR  : ST_SH_IR;
            ST_UP_IR:  next_state_c = tms ? ST_SEL_DR : ST_RTI;
            default:   next_state_c = ST_TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: instruction register, BYPASS/IDCODE registers, BSR control and TDO mux.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1500_1687
)(
    input  logic                   tck,
    input  logic                   reset,
    jtag_tap_controller_if.slave   bus
);

    localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OP_EXTEST);
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OP_SAMPLE);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE);

    tap_state_e          state;
    tap_state_e          next_state_c;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [IR_WIDTH-1:0] ir_value;
    logic                bypass_reg;
    logic [31:0]         idcode_reg;

    logic                enter_tlr_c;
    logic                sel_bsr_c;
    logic                sel_extest_c;
    logic                sel_idcode_c;
    logic                sel_bypass_c;
    logic                tdo_c;
    logic                tdo_en_c;
    logic [BSR_CTRL_W-1:0] bsr_control_c;

    jtag_tap_fsm u_fsm (
        .tck          (tck),
        .reset        (reset),
        .tms          (bus.tms),
        .state        (state),
        .next_state_c (next_state_c)
    );

    // Instruction decode; unknown opcodes fall back to BYPASS
    always_comb begin
        enter_tlr_c  = reset || (next_state_c == ST_TLR);
        sel_extest_c = (ir_value == IR_EXTEST);
        sel_bsr_c    = sel_extest_c || (ir_value == IR_SAMPLE);
        sel_idcode_c = (ir_value == IR_IDCODE);
        sel_bypass_c = !sel_bsr_c && !sel_idcode_c;
    end

    // IR shift/update path; entering TLR restores IDCODE and the capture pattern
    always_ff @(posedge tck) begin
        if (enter_tlr_c) begin
            ir_shift <= IR_CAP_VAL;
            ir_value <= IR_IDCODE;
        end else begin
            case (state)
                ST_CAP_IR: ir_shift <= IR_CAP_VAL;
                ST_SH_IR:  ir_shift <= {bus.tdi, ir_shift[IR_WIDTH-1:1]};
                ST_UP_IR:  ir_value <= ir_shift;
                default:   ;
            endcase
        end
    end

    // BYPASS and IDCODE data registers
    always_ff @(posedge tck) begin
        if (reset) begin
            bypass_reg <= 1'b0;
            idcode_reg <= IDCODE_VALUE;
        end else if (state == ST_CAP_DR) begin
            if (sel_bypass_c) bypass_reg <= 1'b0;
            if (sel_idcode_c) idcode_reg <= IDCODE_VALUE;
        end else if (state == ST_SH_DR) begin
            if (sel_bypass_c) bypass_reg <= bus.tdi;
            if (sel_idcode_c) idcode_reg <= {bus.tdi, idcode_reg[31:1]};
        end
    end

    // Output decode from registered state and active instruction only
    always_comb begin
        tdo_c         = 1'b0;
        tdo_en_c      = 1'b0;
        bsr_control_c = '0;

        bsr_control_c[BSR_MODE]    = sel_extest_c;
        bsr_control_c[BSR_CAPTURE] = sel_bsr_c && (state == ST_CAP_DR);
        bsr_control_c[BSR_SHIFT]   = sel_bsr_c && (state == ST_SH_DR);
        bsr_control_c[BSR_UPDATE]  = sel_bsr_c && (state == ST_UP_DR);

        if (state == ST_SH_IR) begin
            tdo_en_c = 1'b1;
            tdo_c    = ir_shift[0];
        end else if (state == ST_SH_DR) begin
            tdo_en_c = 1'b1;
            if (sel_bsr_c)         tdo_c = bus.bsr_tdo;
            else if (sel_idcode_c) tdo_c = idcode_reg[0];
            else                   tdo_c = bypass_reg;
        end
    end

    assign bus.tdo         = tdo_c;
    assign bus.tdo_en      = tdo_en_c;
    assign bus.bsr_control = bsr_control_c;
    assign bus.tap_state   = 4'(state);
    assign bus.ir_value    = ir_value;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Testbench for jtag_tap_controller: vector table, directed scans, random vs. reference model.
module tb_jtag_tap_controller;

    logic tck;
    logic rst;
    int   checks;
    int   errors;
    bit   model_on;

    jtag_tap_controller_if #(.IR_WIDTH(4)) bus ();

    jtag_tap_controller #(
        .IR_WIDTH     (4),
        .IDCODE_VALUE (32'h1500_1687)
    ) dut (
        .tck   (tck),
        .reset (rst),
        .bus   (bus)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // State codes as listed for the TAP graph
    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
                           S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PADR = 4'h3, S_EX2DR = 4'h0,
                           S_UPDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
                           S_EX1IR = 4'h9, S_PAIR = 4'hB, S_EX2IR = 4'h8, S_UPIR = 4'hD;

    logic [31:0] idc;
    logic [3:0]  nt0 [16];
    logic [3:0]  nt1 [16];

    // Reference model: state, active instruction, shift contents as bit queues (front = next out)
    logic [3:0] m_state;
    logic [3:0] m_ir;
    bit         ir_q [$];
    bit         dr_q [$];
    logic       m_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add_edge(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        nt0[s] = a;
        nt1[s] = b;
    endfunction

    function automatic bit model_bsr_sel();
        return (m_ir == 4'd0) || (m_ir == 4'd1);
    endfunction

    function automatic void model_update(input logic r, input logic t, input logic d);
        logic [3:0] s;
        logic [3:0] ns;
        s  = m_state;
        ns = r ? S_TLR : (t ? nt1[s] : nt0[s]);
        if (!r) begin
            if (s == S_CAPIR) ir_q = '{1'b1, 1'b0, 1'b1, 1'b0};
            if (s == S_SHIR) begin
                void'(ir_q.pop_front());
                ir_q.push_back(d);
            end
            if (s == S_UPIR) for (int i = 0; i < 4; i++) m_ir[i] = ir_q[i];
            if (s == S_CAPDR) begin
                dr_q.delete();
                if (m_ir == 4'd2) for (int i = 0; i < 32; i++) dr_q.push_back(idc[i]);
                else if (!model_bsr_sel()) dr_q.push_back(1'b0);
            end
            if (s == S_SHDR && dr_q.size() > 0) begin
                void'(dr_q.pop_front());
                dr_q.push_back(d);
            end
        end
        if (ns == S_TLR) begin
            m_ir = 4'd2;
            ir_q = '{1'b1, 1'b0, 1'b1, 1'b0};
        end
        m_state = ns;
    endfunction

    task automatic model_check();
        logic       e_tdo;
        logic [3:0] e_ctrl;
        e_tdo = 1'b0;
        if (m_state == S_SHIR) e_tdo = ir_q[0];
        else if (m_state == S_SHDR) e_tdo = model_bsr_sel() ? m_b : (dr_q.size() > 0 ? dr_q[0] : 1'b0);
        e_ctrl    = '0;
        e_ctrl[3] = (m_ir == 4'd0);
        e_ctrl[0] = model_bsr_sel() && (m_state == S_CAPDR);
        e_ctrl[1] = model_bsr_sel() && (m_state == S_SHDR);
        e_ctrl[2] = model_bsr_sel() && (m_state == S_UPDR);
        chk("rnd_state", 32'(bus.tap_state), 32'(m_state));
        chk("rnd_ir", 32'(bus.ir_value), 32'(m_ir));
        chk("rnd_tdo_en", 32'(bus.tdo_en), 32'((m_state == S_SHDR) || (m_state == S_SHIR)));
        chk("rnd_tdo", 32'(bus.tdo), 32'(e_tdo));
        chk("rnd_ctrl", 32'(bus.bsr_control), 32'(e_ctrl));
    endtask

    task automatic step(input logic r, input logic t, input logic d, input logic b);
        rst         = r;
        bus.tms     = t;
        bus.tdi     = d;
        bus.bsr_tdo = b;
        m_b         = b;
        model_update(r, t, d);
        @(posedge tck);
        #1;
        if (model_on) model_check();
    endtask

    // Full IR scan from RUN_TEST_IDLE back to RUN_TEST_IDLE, LSB first
    task automatic ir_scan(input logic [3:0] op);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, (i == 3), op[i], 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
    endtask

    // DR scan of n shift cycles; mode 0 expects tdo=bsr_tdo, mode 1 expects one-bit bypass delay
    task automatic dr_scan(input int n, input int mode, output int cap, output int sh,
                           output int up, output int terr);
        logic d;
        logic prev;
        cap = 0; sh = 0; up = 0; terr = 0; prev = 1'b0;
        for (int k = 0; k < n + 5; k++) begin
            d = 1'($urandom_range(0, 1));
            if (k == 0)          step(0, 1, d, 1'($urandom_range(0, 1)));
            else if (k < 2)      step(0, 0, d, 1'($urandom_range(0, 1)));
            else if (k == 2)     step(0, 0, d, 1'($urandom_range(0, 1)));
            else if (k < n + 3)  begin
                step(0, (k == n + 2), d, 1'($urandom_range(0, 1)));
                prev = d;
            end
            else if (k == n + 3) step(0, 1, d, 1'($urandom_range(0, 1)));
            else                 step(0, 0, d, 1'($urandom_range(0, 1)));
            cap += int'(bus.bsr_control[0]);
            sh  += int'(bus.bsr_control[1]);
            up  += int'(bus.bsr_control[2]);
            if (bus.tdo_en) begin
                if (mode == 0 && bus.tdo !== bus.bsr_tdo) terr++;
                if (mode == 1 && bus.tdo !== prev) terr++;
            end
        end
    endtask

    typedef struct packed {
        logic       rst;
        logic       tms;
        logic       tdi;
        logic       bsr;
        logic [3:0] st;
        logic [3:0] ir;
        logic       tdo;
        logic       en;
        logic [3:0] ctrl;
    } vec_t;

    vec_t vecs [23];

    initial begin
        int cap, sh, up, terr, bias;
        logic [31:0] got;

        checks = 0; errors = 0; model_on = 1'b0;
        idc = 32'h1500_1687;
        rst = 1'b1; bus.tms = 1'b1; bus.tdi = 1'b0; bus.bsr_tdo = 1'b0;
        m_state = S_TLR; m_ir = 4'd2; ir_q = '{1'b1, 1'b0, 1'b1, 1'b0}; dr_q = '{1'b0}; m_b = 1'b0;

        add_edge(S_TLR, S_RTI, S_TLR);       add_edge(S_RTI, S_RTI, S_SELDR);
        add_edge(S_SELDR, S_CAPDR, S_SELIR); add_edge(S_CAPDR, S_SHDR, S_EX1DR);
        add_edge(S_SHDR, S_SHDR, S_EX1DR);   add_edge(S_EX1DR, S_PADR, S_UPDR);
        add_edge(S_PADR, S_PADR, S_EX2DR);   add_edge(S_EX2DR, S_SHDR, S_UPDR);
        add_edge(S_UPDR, S_RTI, S_SELDR);    add_edge(S_SELIR, S_CAPIR, S_TLR);
        add_edge(S_CAPIR, S_SHIR, S_EX1IR);  add_edge(S_SHIR, S_SHIR, S_EX1IR);
        add_edge(S_EX1IR, S_PAIR, S_UPIR);   add_edge(S_PAIR, S_PAIR, S_EX2IR);
        add_edge(S_EX2IR, S_SHIR, S_UPIR);   add_edge(S_UPIR, S_RTI, S_SELDR);

        // rst tms tdi bsr | state ir tdo en ctrl : reset, IR scan of 1111, bypass DR scan
        vecs[0]  = {4'b1100, 4'hF, 4'h2, 2'b00, 4'h0};
        vecs[1]  = {4'b0100, 4'hF, 4'h2, 2'b00, 4'h0};
        vecs[2]  = {4'b0000, 4'hC, 4'h2, 2'b00, 4'h0};
        vecs[3]  = {4'b0100, 4'h7, 4'h2, 2'b00, 4'h0};
        vecs[4]  = {4'b0100, 4'h4, 4'h2, 2'b00, 4'h0};
        vecs[5]  = {4'b0000, 4'hE, 4'h2, 2'b00, 4'h0};
        vecs[6]  = {4'b0000, 4'hA, 4'h2, 2'b11, 4'h0};
        vecs[7]  = {4'b0010, 4'hA, 4'h2, 2'b01, 4'h0};
        vecs[8]  = {4'b0010, 4'hA, 4'h2, 2'b11, 4'h0};
        vecs[9]  = {4'b0010, 4'hA, 4'h2, 2'b01, 4'h0};
        vecs[10] = {4'b0110, 4'h9, 4'h2, 2'b00, 4'h0};
        vecs[11] = {4'b0100, 4'hD, 4'h2, 2'b00, 4'h0};
        vecs[12] = {4'b0000, 4'hC, 4'hF, 2'b00, 4'h0};
        vecs[13] = {4'b0100, 4'h7, 4'hF, 2'b00, 4'h0};
        vecs[14] = {4'b0000, 4'h6, 4'hF, 2'b00, 4'h0};
        vecs[15] = {4'b0000, 4'h2, 4'hF, 2'b01, 4'h0};
        vecs[16] = {4'b0010, 4'h2, 4'hF, 2'b11, 4'h0};
        vecs[17] = {4'b0000, 4'h2, 4'hF, 2'b01, 4'h0};
        vecs[18] = {4'b0010, 4'h2, 4'hF, 2'b11, 4'h0};
        vecs[19] = {4'b0010, 4'h2, 4'hF, 2'b11, 4'h0};
        vecs[20] = {4'b0100, 4'h1, 4'hF, 2'b00, 4'h0};
        vecs[21] = {4'b0100, 4'h5, 4'hF, 2'b00, 4'h0};
        vecs[22] = {4'b0000, 4'hC, 4'hF, 2'b00, 4'h0};

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].rst, vecs[i].tms, vecs[i].tdi, vecs[i].bsr);
            chk($sformatf("vec%0d_state", i), 32'(bus.tap_state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_ir", i), 32'(bus.ir_value), 32'(vecs[i].ir));
            chk($sformatf("vec%0d_tdo", i), 32'(bus.tdo), 32'(vecs[i].tdo));
            chk($sformatf("vec%0d_tdo_en", i), 32'(bus.tdo_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_ctrl", i), 32'(bus.bsr_control), 32'(vecs[i].ctrl));
        end

        // IDCODE read straight out of reset
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("idcode_in_shift", 32'(bus.tap_state), 32'(S_SHDR));
        got = '0;
        for (int i = 0; i < 32; i++) begin
            got[i] = bus.tdo;
            step(0, (i == 31), 0, 0);
        end
        chk("idcode_word", got, idc);
        chk("idcode_exit", 32'(bus.tap_state), 32'(S_EX1DR));
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // EXTEST: mode bit and one capture / n shift / one update pulse
        ir_scan(4'b0000);
        chk("extest_ir", 32'(bus.ir_value), 32'h0);
        chk("extest_ctrl_idle", 32'(bus.bsr_control), 32'h8);
        dr_scan(6, 0, cap, sh, up, terr);
        chk("extest_cap_cnt", 32'(cap), 32'd1);
        chk("extest_sh_cnt", 32'(sh), 32'd6);
        chk("extest_up_cnt", 32'(up), 32'd1);
        chk("extest_tdo_err", 32'(terr), 32'd0);

        // Undefined opcode acts as BYPASS with no BSR pulses
        ir_scan(4'b0110);
        chk("undef_ir", 32'(bus.ir_value), 32'h6);
        dr_scan(5, 1, cap, sh, up, terr);
        chk("undef_ctrl_pulses", 32'(cap + sh + up), 32'd0);
        chk("undef_tdo_err", 32'(terr), 32'd0);
        chk("undef_ctrl_idle", 32'(bus.bsr_control), 32'h0);

        // Reset mid-SHIFT_IR while EXTEST is active
        ir_scan(4'b0000);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("abort_pre_ctrl", 32'(bus.bsr_control), 32'h8);
        step(1, 0, 0, 0);
        chk("abort_state", 32'(bus.tap_state), 32'(S_TLR));
        chk("abort_ir", 32'(bus.ir_value), 32'h2);
        chk("abort_ctrl", 32'(bus.bsr_control), 32'h0);
        chk("abort_tdo_en", 32'(bus.tdo_en), 32'h0);

        // Five TMS=1 edges from PAUSE_DR
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("pause_dr", 32'(bus.tap_state), 32'(S_PADR));
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("tms5_state", 32'(bus.tap_state), 32'(S_TLR));
        chk("tms5_ir", 32'(bus.ir_value), 32'h2);

        // Random TMS/TDI/BSR traffic against the reference model
        model_on = 1'b1;
        bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) bias = 15 + 25 * $urandom_range(0, 2);
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < bias),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        model_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

IEEE 1149.1 TAP controller that sits directly upstream of `boundary_scan_chain` and drives it. It decodes TMS into the 16-state TAP state machine and holds a 4-bit instruction register. It also provides the BYPASS and IDCODE data registers, drives the `control[3:0]` bus of the boundary scan chain, and selects the device TDO source. It is the single entry point between the chip's JTAG pins and every data register in the design.

## Interface
Parameters:
- `IR_WIDTH`, 4: instruction register length.
- `IDCODE_VALUE`, 32'h1500_1687: IDCODE register contents; bit 0 must be 1.

Ports:
- `tck`  in  1  JTAG clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; forces TEST_LOGIC_RESET.
- `tms`  in  1  test mode select.
- `tdi`  in  1  test data in; also routed unchanged to the chain's `tdi`.
- `bsr_tdo`  in  1  serial output of `boundary_scan_chain`.
- `tdo`  out  1  device test data out.
- `tdo_en`  out  1  high only in SHIFT_DR or SHIFT_IR.
- `bsr_control`  out  4  to chain `control`: [0] capture_dr, [1] shift_dr, [2] update_dr, [3] mode.
- `tap_state`  out  4  current state encoding.
- `ir_value`  out  IR_WIDTH  active (updated) instruction.

## Operation
- FSM: the full 1149.1 16-state graph (TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR/IR, CAPTURE, SHIFT, EXIT1, PAUSE, EXIT2, UPDATE for the DR and IR branches). Next state is a function of the current state and `tms` only.
- TMS=1 for 5 consecutive edges reaches TEST_LOGIC_RESET from any state.
- Instructions:
  - EXTEST = 4'b0000: selects BSR, mode=1.
  - SAMPLE/PRELOAD = 4'b0001: selects BSR, mode=0.
  - IDCODE = 4'b0010.
  - BYPASS = 4'b1111.
  - Every other code decodes as BYPASS.
- IR shift register:
  - Loads 4'b0101 on the edge taken in CAPTURE_IR.
  - Shifts right (`tdi` into the MSB) on each edge taken in SHIFT_IR.
  - Copies into `ir_value` on the edge taken in UPDATE_IR.
- In TEST_LOGIC_RESET, `ir_value` = IDCODE and the IR shift register = 4'b0101.
- BYPASS register (1 bit): loads 0 in CAPTURE_DR and loads `tdi` in SHIFT_DR when BYPASS is selected.
- IDCODE register (32 bit): loads `IDCODE_VALUE` in CAPTURE_DR and shifts right with `tdi` into bit 31 in SHIFT_DR when IDCODE is selected.
- `bsr_control` is decoded from the registered state and `ir_value`:
  - [0] high in CAPTURE_DR.
  - [1] high in SHIFT_DR.
  - [2] high in UPDATE_DR.
  - Bits [2:0] assert only when a BSR instruction is active.
  - [3] high whenever EXTEST is active, regardless of state.
- `tdo` source:
  - In SHIFT_IR: IR shift register bit 0.
  - In SHIFT_DR: bit 0 of the selected DR, or `bsr_tdo`.
  - Otherwise: 0.

## Timing
- Reset values:
  - `tap_state` = TEST_LOGIC_RESET (4'hF).
  - `ir_value` = 4'b0010.
  - `bsr_control` = 0.
  - `tdo` = 0, `tdo_en` = 0.
- `reset` has priority over `tms`. Asserting it mid-shift aborts the shift on the next edge, with no UPDATE pulse and `ir_value` set to IDCODE.
- `bsr_control`, `tdo_en` and `tap_state` change only after a rising `tck` edge. They are combinational from registers only, so they are glitch-free.
- `tdo` is combinational from registers; it is not a `tdi` pass-through.
  - In BYPASS, a bit presented on `tdi` appears on `tdo` one edge later.
  - In IDCODE, `tdo` presents bit 0 during the first SHIFT_DR cycle.
- An update pulse is exactly one cycle. PAUSE/EXIT2 loops preserve shift contents.
- A new IR takes effect in the cycle after UPDATE_IR. A DR scan in progress is never re-targeted.

## Structure
- Shared package `jtag_pkg`:
  - The 4-bit state encoding (1149.1 standard values: TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PA_DR=3, EX2_DR=0, UP_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PA_IR=B, EX2_IR=8, UP_IR=D).
  - The instruction opcodes.
  - The `bsr_control` bit indices.
- One sub-module, `jtag_tap_fsm`, holds the state register and next-state logic. Decode and registers stay in the top module.

## Test plan
- Assert `reset` for 1 cycle, then hold `tms`=1 → `tap_state`=4'hF, `ir_value`=4'b0010, `tdo_en`=0.
- IDCODE read: from reset, TMS 0,1,0,0, then 32 SHIFT_DR cycles → `tdo` serialises 32'h1500_1687 LSB first.
- Load BYPASS via IR scan shifting 4'b1111:
  - IR capture shifts out 0101 (LSB first: 1,0,1,0).
  - A DR shift of `tdi` pattern 1,0,1,1 → `tdo` shows 0,1,0,1,1 (one-bit delay).
- Load EXTEST → `bsr_control[3]`=1. A DR scan shows one cycle of [0], N cycles of [1], and one cycle of [2], with `tdo` equal to `bsr_tdo` throughout SHIFT_DR.
- Undefined opcode 4'b0110 → behaves as BYPASS, with `bsr_control[2:0]` never asserted.
- Assert `reset` in the middle of SHIFT_IR after loading 4'b0000 partially → no UPDATE pulse, `ir_value`=4'b0010 next cycle, `bsr_control`=0. Five TMS=1 edges from PAUSE_DR also reach 4'hF.
